ram_request_ctrl: RTL and testbench
===================================

// Module: ram_request_ctrl
// PURPOSE
//  Initiator side of the busy-flag RAM protocol: a direct-mapped, write-through cache controller.
//  It accepts single-word CPU reads/writes, serves read hits locally and drives the RAM port
//  (address/data/mode in, response/out back) for read misses and every write.
//  It sits between the CPU-side test driver and the RAM model, on one clock domain.
// PARAMETERS
//  RAM_SIZE    4096  RAM depth in 32-bit words; every CPU address is reduced modulo RAM_SIZE
//  INDEX_W     6     cache index width; the cache has 2**INDEX_W = 64 lines of one word each
//  ADDR_W      12    log2(RAM_SIZE); the tag is ADDR_W-INDEX_W bits wide
//  MIN_WAIT    2     minimum number of cycles between driving a RAM request and accepting completion
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  cpu_valid     in   1   CPU request present; held with its fields stable until cpu_ready
//  cpu_write     in   1   1 = write, 0 = read
//  cpu_addr      in   32  word address
//  cpu_wdata     in   32  write data
//  cpu_ready     out  1   one-cycle completion pulse
//  cpu_rdata     out  32  read data; valid in the cpu_ready cycle of a read, held afterwards
//  cpu_hit       out  1   1 in the cpu_ready cycle if the request hit a valid line
//  ram_address   out  32  RAM address, zero-extended from ADDR_W bits
//  ram_data      out  32  RAM write data
//  ram_mode      out  1   1 = write, 0 = read
//  ram_response  in   1   1 = RAM busy, 0 = RAM finished
//  ram_out       in   32  RAM read data; valid once ram_response returns to 0 after a read
// BEHAVIOUR
//  Reset: all valid bits are cleared; state goes to IDLE; cpu_ready=0, cpu_rdata=0, cpu_hit=0,
//   ram_address=0, ram_data=0, ram_mode=0. Tag and data arrays are not reset.
//  Address split: a = cpu_addr % RAM_SIZE; index = a[INDEX_W-1:0]; tag = a[ADDR_W-1:INDEX_W].
//  FSM states: IDLE, LOOKUP, RAM_REQ, RAM_WAIT, DONE.
//  - IDLE: when cpu_valid=1, register the address, write flag and data, then go to LOOKUP.
//  - LOOKUP: hit = valid[index] && tag_array[index]==tag.
//     - Read hit: cpu_rdata = line data, cpu_hit=1, then go to DONE. Latency is 2 cycles from acceptance.
//     - Read miss: go to RAM_REQ.
//     - Write, hit or miss: if hit, update the line data in the same cycle. Go to RAM_REQ.
//       Write-through with no write-allocate: a write miss does not fill a line.
//  - RAM_REQ: drive ram_address, ram_data and ram_mode from the registered request; clear the
//     wait counter; go to RAM_WAIT. The RAM outputs stay stable until the next RAM_REQ.
//  - RAM_WAIT: increment the wait counter. Completion requires ram_response=0 AND counter >= MIN_WAIT.
//     An identical repeated request never raises ram_response; the MIN_WAIT rule covers that case,
//     and ram_out still holds the correct value.
//     - On a read, completion fills the line (valid=1, tag, data=ram_out) and sets cpu_rdata=ram_out.
//     - cpu_hit=0 on a miss; a write reports its LOOKUP hit result. Then go to DONE.
//  - DONE: cpu_ready=1 for exactly one cycle; then go to IDLE.
//     In IDLE a new request is accepted one cycle after cpu_ready, at the earliest.
//  While the FSM is not in IDLE, cpu_valid and any field changes are ignored.
//  ram_response=1 seen in IDLE/LOOKUP/DONE is ignored.
//  No timeout: if ram_response stays 1, the FSM stays in RAM_WAIT.
//  Reset mid-operation: the transaction is abandoned and no cpu_ready is issued. ram_mode goes to 0,
//   and a RAM write that was already presented may still complete in the RAM.
//   A stale cache line is impossible because valid bits are cleared.
//  Widths: the counter saturates at MIN_WAIT; ram_address[31:ADDR_W] is always 0.
// STRUCTURE
//  Shared package ram_if_pkg: ADDR_W, INDEX_W, TAG_W, RAM_SIZE and the FSM state encoding,
//   shared with the RAM model and the bench.
//  One sub-module, cache_line_array: valid/tag/data storage with a combinational lookup
//   (index, tag -> hit, rdata), one write port (line write or data-only update) and synchronous clear.
//  ram_request_ctrl holds the FSM, the request registers and the RAM-port registers.
// TESTING
//  1 Reset, then read addr 5 (RAM[5]=0xA5A5_0005) -> miss; ram_mode=0 and ram_address=5;
//    cpu_ready after response falls; cpu_rdata=0xA5A5_0005, cpu_hit=0.
//  2 Read addr 5 again -> hit; cpu_ready 2 cycles after acceptance; same data; no RAM request.
//  3 Write 0x1234 to addr 5 -> line updated and RAM[5]=0x1234. Then read addr 5 -> hit, 0x1234.
//  4 Read addr 69 (same index 5, tag 1) -> miss evicts the line. Then read addr 5 -> miss, 0x1234 from RAM.
//  5 Write addr 4100 (wraps to 4) on a cold cache -> RAM[4] written, no fill. Then read addr 4 -> miss.
//  6 Assert rst in RAM_WAIT of a read miss -> no cpu_ready, outputs at reset values.
//    The next read of the same address -> miss.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared definitions for the busy-flag RAM protocol: geometry, wait rule,
// FSM encoding and the registered CPU request record.
package ram_if_pkg;

   localparam int RAM_SIZE = 4096;
   localparam int ADDR_W   = 12;
   localparam int INDEX_W  = 6;
   localparam int TAG_W    = ADDR_W - INDEX_W;
   localparam int LINES    = 1 << INDEX_W;
   localparam int MIN_WAIT = 2;
   localparam int WAIT_W   = 2;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOOKUP   = 3'd1;
   localparam logic [2:0] ST_RAM_REQ  = 3'd2;
   localparam logic [2:0] ST_RAM_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } cpu_req_t;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[INDEX_W-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:INDEX_W];
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational lookup,
// a single write port (full line fill or data-only update) and synchronous clear.
module cache_line_array
   import ram_if_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] lookup_index,
   input  logic [TAG_W-1:0]   lookup_tag,
   output logic               hit,
   output logic [31:0]        rdata,
   input  logic               wr_en,
   input  logic               wr_fill,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_data
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en && wr_fill) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // NOTE: tag/data storage has no reset; clearing valid_q is what makes every line unusable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_index] <= wr_data;
         if (wr_fill) begin
            tag_q[wr_index] <= wr_tag;
         end
      end
   end

   assign hit   = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
   assign rdata = data_q[lookup_index];

endmodule

// File: rtl/ram_request_ctrl.sv
// Write-through, no-write-allocate direct-mapped cache controller driving the
// busy-flag RAM port for read misses and every write.
module ram_request_ctrl
   import ram_if_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_valid,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic        cpu_hit,
   output logic [31:0] ram_address,
   output logic [31:0] ram_data,
   output logic        ram_mode,
   input  logic        ram_response,
   input  logic [31:0] ram_out
);

   logic [2:0]        state_q;
   cpu_req_t          req_q;
   logic              hit_q;
   logic [WAIT_W-1:0] wait_q;

   logic              lk_hit;
   logic [31:0]       lk_rdata;
   logic              wr_en;
   logic              wr_fill;
   logic [31:0]       wr_data;
   logic              wait_done;

   // Upper address bits vanish in the modulo-RAM_SIZE reduction.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

   cache_line_array u_lines (
      .clk          (clk),
      .rst          (rst),
      .lookup_index (addr_index(req_q.addr)),
      .lookup_tag   (addr_tag(req_q.addr)),
      .hit          (lk_hit),
      .rdata        (lk_rdata),
      .wr_en        (wr_en),
      .wr_fill      (wr_fill),
      .wr_index     (addr_index(req_q.addr)),
      .wr_tag       (addr_tag(req_q.addr)),
      .wr_data      (wr_data)
   );

   // A repeated identical request never raises the busy flag, so the minimum wait also gates completion.
   assign wait_done = !ram_response && (wait_q >= WAIT_W'(MIN_WAIT));
   assign cpu_ready = (state_q == ST_DONE);

   // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_fill = 1'b0;
      wr_data = req_q.wdata;
      if (state_q == ST_LOOKUP && req_q.write && lk_hit) begin
         wr_en = 1'b1;
      end else if (state_q == ST_RAM_WAIT && wait_done && !req_q.write) begin
         wr_en   = 1'b1;
         wr_fill = 1'b1;
         wr_data = ram_out;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         hit_q       <= 1'b0;
         wait_q      <= '0;
         cpu_rdata   <= '0;
         cpu_hit     <= 1'b0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_mode    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cpu_valid) begin
                  req_q.write <= cpu_write;
                  req_q.addr  <= cpu_addr[ADDR_W-1:0];
                  req_q.wdata <= cpu_wdata;
                  state_q     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               hit_q <= lk_hit;
               if (!req_q.write && lk_hit) begin
                  cpu_rdata <= lk_rdata;
                  cpu_hit   <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  state_q   <= ST_RAM_REQ;
               end
            end
            ST_RAM_REQ: begin
               ram_address <= {{(32-ADDR_W){1'b0}}, req_q.addr};
               ram_data    <= req_q.wdata;
               ram_mode    <= req_q.write;
               wait_q      <= '0;
               state_q     <= ST_RAM_WAIT;
            end
            ST_RAM_WAIT: begin
               if (wait_q < WAIT_W'(MIN_WAIT)) begin
                  wait_q <= wait_q + 1'b1;
               end
               if (wait_done) begin
                  if (req_q.write) begin
                     cpu_hit   <= hit_q;
                  end else begin
                     cpu_rdata <= ram_out;
                     cpu_hit   <= 1'b0;
                  end
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               cpu_hit <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_request_ctrl.sv
// Directed bench for ram_request_ctrl with a behavioural busy-flag RAM that
// stays busy for three cycles after any change of its request inputs.
module tb_ram_request_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid;
   logic        cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_hit;
   logic [31:0] ram_address;
   logic [31:0] ram_data;
   logic        ram_mode;
   logic        ram_response;
   logic [31:0] ram_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ram_request_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_valid    (cpu_valid),
      .cpu_write    (cpu_write),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ready    (cpu_ready),
      .cpu_rdata    (cpu_rdata),
      .cpu_hit      (cpu_hit),
      .ram_address  (ram_address),
      .ram_data     (ram_data),
      .ram_mode     (ram_mode),
      .ram_response (ram_response),
      .ram_out      (ram_out)
   );

   // RAM model: a change of {mode,data,address} starts a new request.
   logic [31:0] mem [4096];
   logic [64:0] last_req;
   int          busy_cnt;
   int          req_count;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | i;
      ram_response = 1'b0;
      ram_out      = '0;
      last_req     = '0;
      busy_cnt     = 0;
      req_count    = 0;
   end

   always @(negedge clk) begin
      if ({ram_mode, ram_data, ram_address} !== last_req && !$isunknown(ram_address)) begin
         last_req     = {ram_mode, ram_data, ram_address};
         busy_cnt     = 3;
         ram_response = 1'b1;
         req_count++;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            ram_response = 1'b0;
            if (ram_mode) mem[ram_address[11:0]] = ram_data;
            else          ram_out = mem[ram_address[11:0]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic hit, output int cycles);
      bit seen = 1'b0;
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cycles    = 0;
      while (!seen && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (cpu_ready) seen = 1'b1;
      end
      rdata     = cpu_rdata;
      hit       = cpu_hit;
      cpu_valid = 1'b0;
      check("ready_seen", 32'(seen), 32'd1);
   endtask

   logic [31:0] rd;
   logic        hit;
   int          cyc;
   int          snap;
   bit          saw_ready;
   bit          saw_busy;

   initial begin
      rst       = 1'b1;
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(cpu_ready), 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_hit", 32'(cpu_hit), 32'd0);
      check("rst_ram_addr", ram_address, 32'd0);
      check("rst_ram_data", ram_data, 32'd0);
      check("rst_ram_mode", 32'(ram_mode), 32'd0);

      // 1: cold read miss
      do_req(1'b0, 32'd5, 32'd0, rd, hit, cyc);
      check("t1_rdata", rd, 32'hA5A5_0005);
      check("t1_hit", 32'(hit), 32'd0);
      check("t1_cycles", 32'(cyc), 32'd7);
      check("t1_ram_mode", 32'(ram_mode), 32'd0);
      check("t1_ram_addr", ram_address, 32'd5);

      // 2: read hit, no RAM traffic
      snap = req_count;
      do_req(1'b0, 32'd5, 32'd0, rd, hit, cyc);
      check("t2_rdata", rd, 32'hA5A5_0005);
      check("t2_hit", 32'(hit), 32'd1);
      check("t2_cycles", 32'(cyc), 32'd2);
      check("t2_no_ram_req", 32'(req_count - snap), 32'd0);

      // 3: write hit goes through to RAM and updates the line
      do_req(1'b1, 32'd5, 32'h0000_1234, rd, hit, cyc);
      check("t3_write_hit", 32'(hit), 32'd1);
      check("t3_ram_mode", 32'(ram_mode), 32'd1);
      check("t3_ram_data", ram_data, 32'h0000_1234);
      check("t3_mem5", mem[5], 32'h0000_1234);
      do_req(1'b0, 32'd5, 32'd0, rd, hit, cyc);
      check("t3_read_rdata", rd, 32'h0000_1234);
      check("t3_read_hit", 32'(hit), 32'd1);
      check("t3_read_cycles", 32'(cyc), 32'd2);

      // 4: conflicting tag evicts line 5
      do_req(1'b0, 32'd69, 32'd0, rd, hit, cyc);
      check("t4_rdata69", rd, 32'hA5A5_0045);
      check("t4_hit69", 32'(hit), 32'd0);
      check("t4_ram_addr69", ram_address, 32'd69);
      do_req(1'b0, 32'd5, 32'd0, rd, hit, cyc);
      check("t4_rdata5", rd, 32'h0000_1234);
      check("t4_hit5", 32'(hit), 32'd0);

      // 5: wrapped write miss, no allocate
      do_req(1'b1, 32'd4100, 32'h0000_BEEF, rd, hit, cyc);
      check("t5_write_hit", 32'(hit), 32'd0);
      check("t5_ram_addr", ram_address, 32'd4);
      check("t5_mem4", mem[4], 32'h0000_BEEF);
      do_req(1'b0, 32'd4, 32'd0, rd, hit, cyc);
      check("t5_read_hit", 32'(hit), 32'd0);
      check("t5_read_rdata", rd, 32'h0000_BEEF);

      // 6: reset during RAM_WAIT of a read miss
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = 32'd7;
      cpu_wdata = '0;
      saw_busy  = 1'b0;
      for (int i = 0; i < 20 && !saw_busy; i++) begin
         @(negedge clk);
         if (ram_response) saw_busy = 1'b1;
      end
      check("t6_reached_wait", 32'(saw_busy), 32'd1);
      cpu_valid = 1'b0;
      rst       = 1'b1;
      saw_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw_ready |= cpu_ready;
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_ready |= cpu_ready;
      end
      check("t6_no_ready", 32'(saw_ready), 32'd0);
      check("t6_rdata", cpu_rdata, 32'd0);
      check("t6_hit", 32'(cpu_hit), 32'd0);
      check("t6_ram_addr", ram_address, 32'd0);
      check("t6_ram_mode", 32'(ram_mode), 32'd0);
      do_req(1'b0, 32'd7, 32'd0, rd, hit, cyc);
      check("t6_reread_hit", 32'(hit), 32'd0);
      check("t6_reread_rdata", rd, 32'hA5A5_0007);

      // 7: identical repeated request completes on the minimum wait alone
      do_req(1'b1, 32'd9, 32'h0000_0099, rd, hit, cyc);
      check("t7_first_cycles", 32'(cyc), 32'd7);
      snap = req_count;
      do_req(1'b1, 32'd9, 32'h0000_0099, rd, hit, cyc);
      check("t7_repeat_cycles", 32'(cyc), 32'd6);
      check("t7_repeat_no_busy", 32'(req_count - snap), 32'd0);
      check("t7_repeat_hit", 32'(hit), 32'd0);
      check("t7_mem9", mem[9], 32'h0000_0099);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
